// File: rtl/stream_pkt_fifo.sv
// stream_pkt_fifo: ready/valid FIFO with first-word-fall-through output, per-beat last
// markers, optional packet gating, almost-full/almost-empty thresholds, synchronous
// flush and clearable sticky error flags.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous discard of all stored entries
//   clr_flags             synchronous clear of overflow/underflow
//   s_valid/s_data/s_last source beat; s_ready when a slot is free
//   m_valid/m_data/m_last output beat (FWFT); m_ready from the sink
//   level, pkt_count      stored entries / stored beats carrying last
//   almost_full/empty     level >= AF_THRESH / level <= AE_THRESH
//   overflow, underflow   sticky error flags
module stream_pkt_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PKT_MODE   = 0,
    parameter int unsigned AF_THRESH  = 12,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         clr_flags,
    input  logic                         s_valid,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic                         m_valid,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic                         m_last,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    localparam logic [LW-1:0] FullLevel = LW'(DEPTH);
    localparam logic [LW-1:0] AfLevel   = LW'(AF_THRESH);
    localparam logic [LW-1:0] AeLevel   = LW'(AE_THRESH);

    // Storage keeps {last, data}; not reset.
    logic [DATA_WIDTH:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] pkt_count_q, pkt_count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic [DATA_WIDTH:0] rd_entry;
    logic                push, pop;
    logic                push_last, pop_last;

    assign rd_entry = mem[rd_ptr_q];

    // Outputs derive only from registered state, so there is no s_* -> m_* or
    // m_ready -> s_ready combinational path.
    always_comb begin
        s_ready = (level_q < FullLevel);
        if (PKT_MODE != 0) begin
            // Full override forwards packets longer than DEPTH instead of deadlocking.
            m_valid = (pkt_count_q != '0) || (level_q == FullLevel);
        end else begin
            m_valid = (level_q != '0);
        end
        m_data       = m_valid ? rd_entry[DATA_WIDTH-1:0] : '0;
        m_last       = m_valid ? rd_entry[DATA_WIDTH] : 1'b0;
        level        = level_q;
        pkt_count    = pkt_count_q;
        almost_full  = (level_q >= AfLevel);
        almost_empty = (level_q <= AeLevel);
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    // Flush suppresses both transfers in its cycle.
    assign push      = s_valid & s_ready & ~flush;
    assign pop       = m_valid & m_ready & ~flush;
    assign push_last = push & s_last;
    assign pop_last  = pop & m_last;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        pkt_count_d = pkt_count_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        unique case ({push_last, pop_last})
            2'b10:   pkt_count_d = pkt_count_q + LW'(1);
            2'b01:   pkt_count_d = pkt_count_q - LW'(1);
            default: pkt_count_d = pkt_count_q;
        endcase

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            pkt_count_d = '0;
        end
    end

    // A set condition in the same cycle as clr_flags wins. In packet mode a stalled
    // m_ready with data held back (level > 0) is not an underflow.
    always_comb begin
        overflow_d  = (s_valid & ~s_ready) | (overflow_q & ~clr_flags);
        underflow_d = (m_ready & (level_q == '0)) | (underflow_q & ~clr_flags);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pkt_count_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            pkt_count_q <= pkt_count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {s_last, s_data};
    end

endmodule

// File: tb/tb_stream_pkt_fifo.sv
// Directed bench for stream_pkt_fifo: one stream-mode instance (a_*) and one
// packet-mode instance (b_*), both with DEPTH=16, AF=12, AE=2, 8-bit data.
module tb_stream_pkt_fifo;

    logic clk;
    logic rst_n;

    logic       a_flush, a_clr, a_s_valid, a_s_last, a_s_ready;
    logic [7:0] a_s_data, a_m_data;
    logic       a_m_valid, a_m_last, a_m_ready;
    logic [4:0] a_level, a_pkt_count;
    logic       a_af, a_ae, a_ovf, a_unf;

    logic       b_flush, b_clr, b_s_valid, b_s_last, b_s_ready;
    logic [7:0] b_s_data, b_m_data;
    logic       b_m_valid, b_m_last, b_m_ready;
    logic [4:0] b_level, b_pkt_count;
    logic       b_af, b_ae, b_ovf, b_unf;

    int checks;
    int errors;

    stream_pkt_fifo #(
        .DATA_WIDTH(8), .DEPTH(16), .PKT_MODE(0), .AF_THRESH(12), .AE_THRESH(2)
    ) u_stream (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .clr_flags(a_clr),
        .s_valid(a_s_valid), .s_data(a_s_data), .s_last(a_s_last), .s_ready(a_s_ready),
        .m_valid(a_m_valid), .m_data(a_m_data), .m_last(a_m_last), .m_ready(a_m_ready),
        .level(a_level), .pkt_count(a_pkt_count), .almost_full(a_af),
        .almost_empty(a_ae), .overflow(a_ovf), .underflow(a_unf)
    );

    stream_pkt_fifo #(
        .DATA_WIDTH(8), .DEPTH(16), .PKT_MODE(1), .AF_THRESH(12), .AE_THRESH(2)
    ) u_pkt (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .clr_flags(b_clr),
        .s_valid(b_s_valid), .s_data(b_s_data), .s_last(b_s_last), .s_ready(b_s_ready),
        .m_valid(b_m_valid), .m_data(b_m_data), .m_last(b_m_last), .m_ready(b_m_ready),
        .level(b_level), .pkt_count(b_pkt_count), .almost_full(b_af),
        .almost_empty(b_ae), .overflow(b_ovf), .underflow(b_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout reached before summary");
        $fatal(1, "timeout");
    end

    // Advance one clock; sampling happens 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (a_s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got %b exp 1", a_s_ready); end
        checks++; if (a_m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b exp 0", a_m_valid); end
        checks++; if (a_m_data !== 8'h00) begin errors++; $display("FAIL rst_m_data got %h exp 00", a_m_data); end
        checks++; if (a_m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last got %b exp 0", a_m_last); end
        checks++; if (a_level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", a_level); end
        checks++; if (a_pkt_count !== 5'd0) begin errors++; $display("FAIL rst_pkt_count got %0d exp 0", a_pkt_count); end
        checks++; if (a_ae !== 1'b1) begin errors++; $display("FAIL rst_almost_empty got %b exp 1", a_ae); end
        checks++; if (a_af !== 1'b0) begin errors++; $display("FAIL rst_almost_full got %b exp 0", a_af); end
        checks++; if ({a_ovf, a_unf} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b exp 00", {a_ovf, a_unf}); end
        checks++; if ({b_s_ready, b_m_valid} !== 2'b10) begin errors++; $display("FAIL rst_pkt_hs got %b exp 10", {b_s_ready, b_m_valid}); end
    endtask

    task automatic test_fill_drain();
        a_m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_s_valid = 1'b1; a_s_data = 8'(i); a_s_last = 1'b0;
            step();
            checks++; if (a_level !== 5'(i + 1)) begin errors++; $display("FAIL fill_level got %0d exp %0d", a_level, i + 1); end
            checks++; if (a_af !== (i + 1 >= 12)) begin errors++; $display("FAIL fill_af lvl %0d got %b exp %b", i + 1, a_af, (i + 1 >= 12)); end
            checks++; if (a_s_ready !== (i + 1 < 16)) begin errors++; $display("FAIL fill_s_ready lvl %0d got %b exp %b", i + 1, a_s_ready, (i + 1 < 16)); end
        end
        a_s_valid = 1'b0;
        a_m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (a_m_valid !== 1'b1 || a_m_data !== 8'(i)) begin errors++; $display("FAIL drain_data got v%b %h exp v1 %h", a_m_valid, a_m_data, 8'(i)); end
            step();
            checks++; if (a_level !== 5'(15 - i)) begin errors++; $display("FAIL drain_level got %0d exp %0d", a_level, 15 - i); end
            checks++; if (a_ae !== (15 - i <= 2)) begin errors++; $display("FAIL drain_ae lvl %0d got %b exp %b", 15 - i, a_ae, (15 - i <= 2)); end
        end
        a_m_ready = 1'b0;
        checks++; if (a_m_valid !== 1'b0 || a_m_data !== 8'h00) begin errors++; $display("FAIL drain_empty got v%b %h exp v0 00", a_m_valid, a_m_data); end
    endtask

    task automatic test_wrap_concurrent();
        logic [7:0] wv;
        logic [7:0] rv;
        wv = 8'h20; rv = 8'h20;
        a_m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_s_valid = 1'b1; a_s_data = wv; a_s_last = 1'b0;
            step();
            wv++;
        end
        checks++; if (a_level !== 5'd8) begin errors++; $display("FAIL wrap_prefill got %0d exp 8", a_level); end
        a_m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a_s_data = wv;
            checks++; if (a_m_data !== rv) begin errors++; $display("FAIL wrap_data got %h exp %h", a_m_data, rv); end
            step();
            wv++; rv++;
            checks++; if (a_level !== 5'd8) begin errors++; $display("FAIL wrap_level got %0d exp 8", a_level); end
        end
        a_s_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (a_m_data !== rv) begin errors++; $display("FAIL wrap_tail got %h exp %h", a_m_data, rv); end
            step();
            rv++;
        end
        a_m_ready = 1'b0;
        checks++; if ({a_level, a_ovf, a_unf} !== 7'd0) begin errors++; $display("FAIL wrap_end got lvl %0d ov %b un %b exp 0 0 0", a_level, a_ovf, a_unf); end
    endtask

    task automatic test_errors();
        a_m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_s_valid = 1'b1; a_s_data = 8'h40 + 8'(i); a_s_last = 1'b0;
            step();
        end
        a_s_data = 8'hEE;
        step();
        a_s_valid = 1'b0;
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", a_ovf); end
        checks++; if (a_level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d exp 16", a_level); end
        a_m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (a_m_data !== 8'h40 + 8'(i)) begin errors++; $display("FAIL ovf_intact got %h exp %h", a_m_data, 8'h40 + 8'(i)); end
            step();
        end
        checks++; if (a_unf !== 1'b0) begin errors++; $display("FAIL unf_early got %b exp 0", a_unf); end
        step();
        a_m_ready = 1'b0;
        checks++; if (a_unf !== 1'b1) begin errors++; $display("FAIL unf_set got %b exp 1", a_unf); end
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        checks++; if ({a_ovf, a_unf} !== 2'b00) begin errors++; $display("FAIL clr_flags got %b exp 00", {a_ovf, a_unf}); end
        for (int i = 0; i < 16; i++) begin
            a_s_valid = 1'b1; a_s_data = 8'(i);
            step();
        end
        a_clr = 1'b1;
        step();
        a_s_valid = 1'b0;
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL clr_vs_set got %b exp 1", a_ovf); end
        step();
        a_clr = 1'b0;
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL clr_again got %b exp 0", a_ovf); end
    endtask

    task automatic test_flush();
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        checks++; if (a_level !== 5'd0) begin errors++; $display("FAIL flush_full got %0d exp 0", a_level); end
        for (int i = 0; i < 5; i++) begin
            a_s_valid = 1'b1; a_s_data = 8'h60 + 8'(i); a_s_last = (i == 1 || i == 4);
            step();
        end
        a_s_last = 1'b0;
        checks++; if (a_level !== 5'd5 || a_pkt_count !== 5'd2) begin errors++; $display("FAIL flush_pre got %0d/%0d exp 5/2", a_level, a_pkt_count); end
        a_s_data = 8'h77; a_m_ready = 1'b1; a_flush = 1'b1;
        step();
        a_flush = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b0;
        checks++; if (a_level !== 5'd0 || a_pkt_count !== 5'd0) begin errors++; $display("FAIL flush_cnt got %0d/%0d exp 0/0", a_level, a_pkt_count); end
        checks++; if ({a_m_valid, a_ovf, a_unf} !== 3'b000) begin errors++; $display("FAIL flush_state got %b exp 000", {a_m_valid, a_ovf, a_unf}); end
        a_s_valid = 1'b1; a_s_data = 8'h99;
        step();
        a_s_valid = 1'b0;
        checks++; if (a_level !== 5'd1 || a_m_data !== 8'h99) begin errors++; $display("FAIL flush_after got %0d %h exp 1 99", a_level, a_m_data); end
        a_m_ready = 1'b1;
        step();
        a_m_ready = 1'b0;
        checks++; if (a_level !== 5'd0) begin errors++; $display("FAIL flush_pop got %0d exp 0", a_level); end
    endtask

    task automatic test_packet();
        b_m_ready = 1'b0;
        b_s_valid = 1'b1; b_s_data = 8'hA1; b_s_last = 1'b0;
        step();
        checks++; if (b_m_valid !== 1'b0) begin errors++; $display("FAIL pkt_gate1 got %b exp 0", b_m_valid); end
        b_m_ready = 1'b1; b_s_data = 8'hA2;
        step();
        checks++; if (b_m_valid !== 1'b0 || b_level !== 5'd2) begin errors++; $display("FAIL pkt_gate2 got v%b lvl %0d exp v0 2", b_m_valid, b_level); end
        b_s_data = 8'hA3; b_s_last = 1'b1;
        step();
        b_s_valid = 1'b0; b_s_last = 1'b0;
        checks++; if (b_m_valid !== 1'b1 || b_pkt_count !== 5'd1 || b_m_data !== 8'hA1 || b_m_last !== 1'b0) begin
            errors++; $display("FAIL pkt_open got v%b pc %0d %h l%b exp v1 1 a1 l0", b_m_valid, b_pkt_count, b_m_data, b_m_last); end
        step();
        checks++; if (b_m_data !== 8'hA2 || b_m_last !== 1'b0) begin errors++; $display("FAIL pkt_beat2 got %h l%b exp a2 l0", b_m_data, b_m_last); end
        step();
        checks++; if (b_m_data !== 8'hA3 || b_m_last !== 1'b1 || b_pkt_count !== 5'd1) begin
            errors++; $display("FAIL pkt_beat3 got %h l%b pc %0d exp a3 l1 1", b_m_data, b_m_last, b_pkt_count); end
        step();
        b_m_ready = 1'b0;
        checks++; if ({b_m_valid, b_level, b_pkt_count} !== 11'd0) begin errors++; $display("FAIL pkt_done got v%b %0d/%0d exp v0 0/0", b_m_valid, b_level, b_pkt_count); end
        checks++; if (b_unf !== 1'b0) begin errors++; $display("FAIL pkt_no_unf got %b exp 0", b_unf); end
    endtask

    task automatic test_oversize();
        b_m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b_s_valid = 1'b1; b_s_data = 8'h10 + 8'(i); b_s_last = 1'b0;
            step();
            checks++; if (b_m_valid !== (i == 15)) begin errors++; $display("FAIL big_gate lvl %0d got %b exp %b", i + 1, b_m_valid, (i == 15)); end
        end
        b_s_valid = 1'b0;
        checks++; if (b_m_data !== 8'h10) begin errors++; $display("FAIL big_first got %h exp 10", b_m_data); end
        b_m_ready = 1'b1;
        step();
        b_m_ready = 1'b0;
        checks++; if (b_m_valid !== 1'b0 || b_level !== 5'd15) begin errors++; $display("FAIL big_regate got v%b %0d exp v0 15", b_m_valid, b_level); end
        b_s_valid = 1'b1; b_s_data = 8'hF0; b_s_last = 1'b1;
        step();
        b_s_valid = 1'b0; b_s_last = 1'b0;
        b_m_ready = 1'b1;
        for (int i = 1; i < 17; i++) begin
            logic [7:0] exp_d;
            exp_d = (i == 16) ? 8'hF0 : 8'h10 + 8'(i);
            checks++; if (b_m_valid !== 1'b1 || b_m_data !== exp_d || b_m_last !== (i == 16)) begin
                errors++; $display("FAIL big_drain got v%b %h l%b exp v1 %h l%b", b_m_valid, b_m_data, b_m_last, exp_d, (i == 16)); end
            step();
        end
        b_m_ready = 1'b0;
        checks++; if (b_level !== 5'd0 || b_pkt_count !== 5'd0) begin errors++; $display("FAIL big_end got %0d/%0d exp 0/0", b_level, b_pkt_count); end
    endtask

    task automatic test_async_reset();
        a_s_valid = 1'b1; a_s_data = 8'h55; a_s_last = 1'b1;
        step(); step(); step();
        checks++; if (a_level !== 5'd3) begin errors++; $display("FAIL ar_pre got %0d exp 3", a_level); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (a_level !== 5'd0 || a_pkt_count !== 5'd0) begin errors++; $display("FAIL ar_cnt got %0d/%0d exp 0/0", a_level, a_pkt_count); end
        checks++; if ({a_m_valid, a_s_ready, a_ae, a_af} !== 4'b0110 || a_m_data !== 8'h00) begin
            errors++; $display("FAIL ar_outs got %b %h exp 0110 00", {a_m_valid, a_s_ready, a_ae, a_af}, a_m_data); end
        a_s_valid = 1'b0; a_s_last = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (a_level !== 5'd0 || a_m_valid !== 1'b0) begin errors++; $display("FAIL ar_after got %0d v%b exp 0 v0", a_level, a_m_valid); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        a_flush = 0; a_clr = 0; a_s_valid = 0; a_s_data = 0; a_s_last = 0; a_m_ready = 0;
        b_flush = 0; b_clr = 0; b_s_valid = 0; b_s_data = 0; b_s_last = 0; b_m_ready = 0;
        #2;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        test_fill_drain();
        test_wrap_concurrent();
        test_errors();
        test_flush();
        test_packet();
        test_oversize();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
